// File: rtl/control_sequencer.sv
// control_sequencer: instruction register, microstep counter and microcode
// decoder for the 8-bit bus computer. Produces the 16-bit control word that
// drives the ALU, RAM, program counter and output stages.
//
// Optional feature: define CONTROL_SEQUENCER_COND_JUMP_EN to add the carry and
// zero flag registers and the JC (0x7) / JZ (0x8) conditional jumps. Without
// it, 0x7/0x8 behave as NOP and FI is never asserted.
module control_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int STEP_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] bus_in,
   input  logic                  alu_carry,
   input  logic                  alu_zero,
   output logic [15:0]           ctrl,
   output logic [3:0]            operand_out,
   output logic [3:0]            opcode,
   output logic [STEP_WIDTH-1:0] step,
   output logic                  halted
);

   // Control word bit positions
   localparam logic [15:0] C_HLT = 16'h8000;
   localparam logic [15:0] C_MI  = 16'h4000;
   localparam logic [15:0] C_RI  = 16'h2000;
   localparam logic [15:0] C_RO  = 16'h1000;
   localparam logic [15:0] C_IO  = 16'h0800;
   localparam logic [15:0] C_II  = 16'h0400;
   localparam logic [15:0] C_AI  = 16'h0200;
   localparam logic [15:0] C_AO  = 16'h0100;
   localparam logic [15:0] C_EO  = 16'h0080;
   localparam logic [15:0] C_SU  = 16'h0040;
   localparam logic [15:0] C_BI  = 16'h0020;
   localparam logic [15:0] C_OI  = 16'h0010;
   localparam logic [15:0] C_CE  = 16'h0008;
   localparam logic [15:0] C_CO  = 16'h0004;
   localparam logic [15:0] C_J   = 16'h0002;
`ifdef CONTROL_SEQUENCER_COND_JUMP_EN
   localparam logic [15:0] C_FI  = 16'h0001;
`else
   // No flag registers to load, so FI stays silent
   localparam logic [15:0] C_FI  = 16'h0000;
`endif

   localparam int II_BIT  = 10;
   localparam int HLT_BIT = 15;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LDA = 4'h1,
      OP_ADD = 4'h2,
      OP_SUB = 4'h3,
      OP_STA = 4'h4,
      OP_LDI = 4'h5,
      OP_JMP = 4'h6,
      OP_JC  = 4'h7,
      OP_JZ  = 4'h8,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_t;

   typedef enum logic [STEP_WIDTH-1:0] {
      T0 = STEP_WIDTH'(0),
      T1 = STEP_WIDTH'(1),
      T2 = STEP_WIDTH'(2),
      T3 = STEP_WIDTH'(3),
      T4 = STEP_WIDTH'(4)
   } step_t;

   logic [DATA_WIDTH-1:0] ir;
   step_t                 step_q;
   step_t                 step_next;
   step_t                 last_step;
   logic [15:0]           ctrl_word;
   opcode_t               op;

   assign op          = opcode_t'(ir[DATA_WIDTH-1 -: 4]);
   assign opcode      = ir[DATA_WIDTH-1 -: 4];
   assign operand_out = ir[3:0];
   assign step        = step_q;

`ifdef CONTROL_SEQUENCER_COND_JUMP_EN
   logic carry_flag;
   logic zero_flag;

   // Flags capture the ALU result only on cycles that assert FI
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
      end else if (ctrl_word[0]) begin
         carry_flag <= alu_carry;
         zero_flag  <= alu_zero;
      end
   end
`else
   wire unused_alu = alu_carry ^ alu_zero;
`endif

   // Last microstep of the current instruction; fetch steps never look at it
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      last_step = T2;
      case (op)
         OP_LDA, OP_STA: last_step = T3;
         OP_ADD, OP_SUB: last_step = T4;
         default:        last_step = T2;
      endcase
   end

   // Step advance: return to T0 after the last step, never go past T4
   always_comb begin
      step_next = step_t'(step_q + 1'b1);
      if (step_q >= last_step || step_q >= T4) step_next = T0;
   end

   // Microcode decode: fetch at T0/T1, then opcode-specific execute steps
   always_comb begin
      ctrl_word = 16'h0000;
      if (!halted) begin
         case (step_q)
            T0: ctrl_word = C_MI | C_CO;
            T1: ctrl_word = C_RO | C_II | C_CE;
            default: begin
               case (op)
                  OP_LDA: begin
                     if (step_q == T2)      ctrl_word = C_IO | C_MI;
                     else if (step_q == T3) ctrl_word = C_RO | C_AI;
                  end
                  OP_ADD, OP_SUB: begin
                     if (step_q == T2)      ctrl_word = C_IO | C_MI;
                     else if (step_q == T3) ctrl_word = C_RO | C_BI;
                     else if (step_q == T4) ctrl_word = C_EO | C_AI | C_FI
                                                        | ((op == OP_SUB) ? C_SU : 16'h0000);
                  end
                  OP_STA: begin
                     if (step_q == T2)      ctrl_word = C_IO | C_MI;
                     else if (step_q == T3) ctrl_word = C_AO | C_RI;
                  end
                  OP_LDI: if (step_q == T2) ctrl_word = C_IO | C_AI;
                  OP_JMP: if (step_q == T2) ctrl_word = C_IO | C_J;
`ifdef CONTROL_SEQUENCER_COND_JUMP_EN
                  OP_JC:  if (step_q == T2 && carry_flag) ctrl_word = C_IO | C_J;
                  OP_JZ:  if (step_q == T2 && zero_flag)  ctrl_word = C_IO | C_J;
`endif
                  OP_OUT: if (step_q == T2) ctrl_word = C_AO | C_OI;
                  OP_HLT: if (step_q == T2) ctrl_word = C_HLT;
                  default: ctrl_word = 16'h0000;
               endcase
            end
         endcase
      end
   end

   // Reset takes every bus driver off immediately, not at the next edge
   assign ctrl = rst_n ? ctrl_word : 16'h0000;

   // Sequencer state: IR capture, step counter and halt latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir     <= '0;
         step_q <= T0;
         halted <= 1'b0;
      end else if (!halted) begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         if (ctrl_word[HLT_BIT]) halted <= 1'b1;
         else                    step_q <= step_next;
         if (ctrl_word[II_BIT])  ir     <= bus_in;
      end
   end

endmodule
